// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 serialiser that drives the RS232 Tx pin.
// Producers push bursts through a valid/ready handshake. The bit-timing FSM
// drains the FIFO one frame at a time, sending the LSB first.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT    = 1250,
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tx_valid,
    input  logic [7:0]               tx_byte,
    output logic                     tx_ready,
    output logic                     tx,
    output logic                     is_transmitting,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count
);

    localparam int Depth = 1 << FIFO_DEPTH_LOG2;
    localparam int PtrW  = FIFO_DEPTH_LOG2;
    localparam int CntW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [FIFO_DEPTH_LOG2:0] FullCount = (FIFO_DEPTH_LOG2 + 1)'(Depth);
    localparam logic [CntW-1:0]          LastClk   = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [7:0]             mem_q [Depth];
    logic [PtrW-1:0]        wrPtr_q, wrPtr_d;
    logic [PtrW-1:0]        rdPtr_q, rdPtr_d;
    logic [FIFO_DEPTH_LOG2:0] count_q, count_d;

    state_t                 state_q, state_d;
    logic [CntW-1:0]        clkCnt_q, clkCnt_d;
    logic [2:0]             bitIdx_q, bitIdx_d;
    logic [7:0]             shift_q, shift_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;

    logic                   push;
    logic                   pop;
    logic                   clkDone;
    logic [7:0]             headByte;

    assign tx_ready        = (count_q != FullCount);
    assign push            = tx_valid && tx_ready;
    assign clkDone         = (clkCnt_q == LastClk);
    assign headByte        = mem_q[rdPtr_q];
    assign tx              = tx_q;
    assign is_transmitting = busy_q;
    assign fifo_count      = count_q;

    // FIFO storage: the byte is written at the write pointer on an accepted push
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= tx_byte;
        end
    end

    // FIFO bookkeeping: pointers wrap naturally, and a simultaneous push and pop keeps the count
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push) begin
            wrPtr_d = wrPtr_q + PtrW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (FIFO_DEPTH_LOG2 + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_DEPTH_LOG2 + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer and count registers, cleared by reset so queued bytes are discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Frame FSM: the next line level is registered, so tx changes only on the clock edge
    always_comb begin
        state_d  = state_q;
        clkCnt_d = clkCnt_q;
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (count_q != '0) begin
                    pop      = 1'b1;
                    shift_d  = headByte;
                    state_d  = START;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                    clkCnt_d = '0;
                    bitIdx_d = '0;
                end
            end
            START: begin
                if (clkDone) begin
                    state_d  = DATA;
                    tx_d     = shift_q[0];
                    clkCnt_d = '0;
                    bitIdx_d = '0;
                end else begin
                    clkCnt_d = clkCnt_q + CntW'(1);
                end
            end
            DATA: begin
                if (clkDone) begin
                    clkCnt_d = '0;
                    if (bitIdx_q == 3'd7) begin
                        state_d  = STOP;
                        tx_d     = 1'b1;
                        bitIdx_d = '0;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                        shift_d  = {1'b0, shift_q[7:1]};
                        tx_d     = shift_q[1];
                    end
                end else begin
                    clkCnt_d = clkCnt_q + CntW'(1);
                end
            end
            STOP: begin
                if (clkDone) begin
                    clkCnt_d = '0;
                    bitIdx_d = '0;
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = headByte;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    clkCnt_d = clkCnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Frame FSM registers: reset abandons any frame in progress and returns the line to idle-high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            clkCnt_q <= '0;
            bitIdx_q <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            clkCnt_q <= clkCnt_d;
            bitIdx_q <= bitIdx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo. Every accepted byte is pushed into a scoreboard
// queue. A line monitor decodes each frame on tx and compares it against the
// head of that queue.
module tb_uart_tx_fifo;

    localparam int CLKS_PER_BIT    = 4;
    localparam int FIFO_DEPTH_LOG2 = 3;
    localparam int FrameLen        = 10 * CLKS_PER_BIT;

    logic                     clk;
    logic                     rst_n;
    logic                     tx_valid;
    logic [7:0]               tx_byte;
    logic                     tx_ready;
    logic                     tx;
    logic                     is_transmitting;
    logic [FIFO_DEPTH_LOG2:0] fifo_count;

    int checks = 0;
    int errors = 0;
    int cycleCnt = 0;

    logic [7:0] expQ[$];
    int         frameStarts[$];

    logic       monActive = 1'b0;
    int         monCycle = 0;
    int         lineErrs = 0;
    logic [7:0] monByte = 8'h00;
    logic [7:0] monExp = 8'h00;
    logic       monHasExp = 1'b0;
    logic       trackPeak = 1'b0;
    int         peak = 0;

    uart_tx_fifo #(
        .CLKS_PER_BIT   (CLKS_PER_BIT),
        .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tx_valid       (tx_valid),
        .tx_byte        (tx_byte),
        .tx_ready       (tx_ready),
        .tx             (tx),
        .is_transmitting(is_transmitting),
        .fifo_count     (fifo_count)
    );

    // 10 ns clock; edges are numbered by cycleCnt so that latencies can be checked
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cycleCnt <= cycleCnt + 1;
    end

    // Watchdog so the run always ends on its own
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish by 500000 ns, expected finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    // Line monitor: decodes 8N1 frames on tx and scores each one against the expected queue
    initial begin : monitor
        int   bitNo;
        logic expBit;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                monActive = 1'b0;
            end else begin
                if (trackPeak && int'(fifo_count) > peak) peak = int'(fifo_count);
                if (!monActive && tx === 1'b0) begin
                    monActive = 1'b1;
                    monCycle  = 0;
                    lineErrs  = 0;
                    monByte   = 8'h00;
                    frameStarts.push_back(cycleCnt);
                    if (expQ.size() == 0) begin
                        monHasExp = 1'b0;
                        monExp    = 8'h00;
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_frame: got start bit after edge %0d, expected no frame", cycleCnt);
                    end else begin
                        monHasExp = 1'b1;
                        monExp    = expQ.pop_front();
                    end
                end
                if (monActive) begin
                    bitNo = monCycle / CLKS_PER_BIT;
                    if (bitNo == 0)      expBit = 1'b0;
                    else if (bitNo == 9) expBit = 1'b1;
                    else                 expBit = monExp[bitNo-1];
                    if (tx !== expBit || is_transmitting !== 1'b1) lineErrs++;
                    if (bitNo >= 1 && bitNo <= 8 && (monCycle % CLKS_PER_BIT) == CLKS_PER_BIT / 2)
                        monByte[bitNo-1] = tx;
                    monCycle++;
                    if (monCycle == FrameLen) begin
                        monActive = 1'b0;
                        if (monHasExp) begin
                            checks++;
                            if (monByte !== monExp || lineErrs != 0) begin
                                errors++;
                                $display("[TB] FAIL frame: got byte %h with %0d bad line cycles, expected byte %h with 0",
                                         monByte, lineErrs, monExp);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Called at a negedge: holds the byte on the bus until the DUT accepts it, then returns at the next negedge
    task automatic applyStimulus(input logic [7:0] b, output int acceptEdge);
        int n;
        n = 0;
        acceptEdge = -1;
        tx_valid = 1'b1;
        tx_byte  = b;
        while (acceptEdge < 0 && n < 500) begin
            if (tx_ready === 1'b1) begin
                acceptEdge = cycleCnt + 1;
                expQ.push_back(b);
            end
            @(negedge clk);
            n++;
        end
        if (acceptEdge < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got no acceptance of %h in 500 cycles, expected acceptance", b);
        end
    endtask

    task automatic releaseInputs();
        tx_valid = 1'b0;
        tx_byte  = 8'h00;
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while ((expQ.size() != 0 || monActive || is_transmitting !== 1'b0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_drained"}, int'(n < 2000), 1);
        repeat (3) @(negedge clk);
    endtask

    function automatic int startAt(input int i);
        if (i < frameStarts.size()) return frameStarts[i];
        return -1;
    endfunction

    initial begin
        int e0, e1, e2, e3, fallCycle, bad;
        int acc[10];
        logic seenBusy;

        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_byte  = 8'h00;

        // Reset state, then 100 quiet cycles after release
        repeat (3) @(negedge clk);
        checkOutput("reset_tx", int'(tx), 1);
        checkOutput("reset_tx_ready", int'(tx_ready), 1);
        checkOutput("reset_fifo_count", int'(fifo_count), 0);
        checkOutput("reset_is_transmitting", int'(is_transmitting), 0);
        rst_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_ready !== 1'b1 || fifo_count !== '0 || is_transmitting !== 1'b0) bad++;
        end
        checkOutput("idle_bad_cycles", bad, 0);

        // Single byte 0xA5: start at N+1, busy falls at N+41
        frameStarts.delete();
        applyStimulus(8'hA5, e0);
        releaseInputs();
        seenBusy  = 1'b0;
        fallCycle = -1;
        for (int n = 0; n < 100 && fallCycle < 0; n++) begin
            @(negedge clk);
            if (is_transmitting === 1'b1) seenBusy = 1'b1;
            else if (seenBusy) fallCycle = cycleCnt;
        end
        checkOutput("a5_start_edge", startAt(0), e0 + 1);
        checkOutput("a5_busy_fall_edge", fallCycle, e0 + 41);
        waitIdle("a5");

        // Back-to-back: three contiguous frames, peak count 2
        frameStarts.delete();
        peak = 0;
        trackPeak = 1'b1;
        applyStimulus(8'h00, e0);
        applyStimulus(8'hFF, e1);
        applyStimulus(8'h55, e2);
        releaseInputs();
        waitIdle("b2b");
        trackPeak = 1'b0;
        checkOutput("b2b_first_start", startAt(0), e0 + 1);
        checkOutput("b2b_gap_1", startAt(1) - startAt(0), FrameLen);
        checkOutput("b2b_gap_2", startAt(2) - startAt(1), FrameLen);
        checkOutput("b2b_peak_count", peak, 2);

        // Full FIFO: 9 accepted at once, 10th waits for the next pop
        frameStarts.delete();
        for (int i = 0; i < 9; i++) applyStimulus(8'h10 + 8'(i), acc[i]);
        checkOutput("full_ninth_edge", acc[8], acc[0] + 8);
        checkOutput("full_tx_ready", int'(tx_ready), 0);
        checkOutput("full_fifo_count", int'(fifo_count), 8);
        applyStimulus(8'hC3, acc[9]);
        releaseInputs();
        checkOutput("full_tenth_edge", acc[9], acc[0] + 42);
        waitIdle("full");

        // Push at the same edge the FSM pops from the stop bit: count stays at 1
        frameStarts.delete();
        applyStimulus(8'h3C, e0);
        applyStimulus(8'h81, e1);
        releaseInputs();
        while (cycleCnt < e0 + 40) @(negedge clk);
        checkOutput("simul_count_before", int'(fifo_count), 1);
        applyStimulus(8'h7E, e2);
        releaseInputs();
        checkOutput("simul_accept_edge", e2, e0 + 41);
        checkOutput("simul_count_after", int'(fifo_count), 1);
        waitIdle("simul");

        // Reset during DATA bit 3 with two bytes queued
        frameStarts.delete();
        applyStimulus(8'hE7, e0);
        applyStimulus(8'h12, e1);
        applyStimulus(8'h34, e3);
        releaseInputs();
        while (cycleCnt < e0 + 18) @(negedge clk);
        checkOutput("midreset_queued_before", int'(fifo_count), 2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_tx", int'(tx), 1);
        checkOutput("midreset_fifo_count", int'(fifo_count), 0);
        checkOutput("midreset_is_transmitting", int'(is_transmitting), 0);
        checkOutput("midreset_tx_ready", int'(tx_ready), 1);
        expQ.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || is_transmitting !== 1'b0 || fifo_count !== '0) bad++;
        end
        checkOutput("midreset_quiet_cycles", bad, 0);
        checkOutput("midreset_frames_after", frameStarts.size(), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit side of the board's RS232 link: buffers bytes from fabric logic and serialises them on the Tx pin as 8N1 frames, LSB first.
- Complements the receive path, which consumes bytes arriving on RS232_Rx. Typical use: echo or report bytes back to the host.
- Contains a small byte FIFO and a bit-timing FSM, so producers can push bursts without tracking line timing.

Parameters:
- CLKS_PER_BIT, 1250, clk cycles per serial bit (12 MHz / 9600 baud); legal range ≥ 2.
- FIFO_DEPTH_LOG2, 3, log2 of FIFO depth (default 8 entries); legal range ≥ 1.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_valid  input  1  producer has a byte on tx_byte.
- tx_byte  input  8  byte to enqueue.
- tx_ready  output  1  FIFO can accept a byte this cycle.
- tx  output  1  serial line (idle high), drives RS232_Tx.
- is_transmitting  output  1  high while a frame (start..stop) is on the line.
- fifo_count  output  FIFO_DEPTH_LOG2+1  bytes currently queued (excludes byte in flight).

Behaviour:
- Reset (rst_n low, async): tx=1, is_transmitting=0, fifo_count=0, tx_ready=1, FSM=IDLE, FIFO pointers cleared. Release is synchronous in effect; first push is accepted on the first rising edge with rst_n high.
- Push handshake:
  - A byte is written on a rising edge where tx_valid && tx_ready.
  - tx_ready = (fifo_count != 2^FIFO_DEPTH_LOG2), combinational from registered count.
  - tx_valid while not ready: no write, no error, byte ignored; the producer holds it.
- FIFO: circular buffer, pointers wrap modulo depth. Same-edge push and pop leaves count unchanged. Push when full never occurs, because tx_ready gates it.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If fifo_count>0 at an edge, pop head into the shift register, go to START, tx=0 and is_transmitting=1 from that edge.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with tx=shift[0].
  - DATA: each bit is held CLKS_PER_BIT cycles, then shift right. After bit 7 completes, go to STOP with tx=1.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles. At the end, if fifo_count>0, pop and go directly to START (no idle gap). Otherwise go to IDLE with is_transmitting=0.
- Latency: a byte pushed into an empty FIFO while IDLE at edge N makes tx fall at edge N+1. Frame length is exactly 10*CLKS_PER_BIT cycles.
- Timing: the bit counter is 0..CLKS_PER_BIT-1 and the bit index is 0..7. Both reset on every state change.
- tx is registered, so there are no glitches.
- Reset mid-frame: tx returns to 1 immediately. The partial frame is abandoned, the queued bytes are discarded and the FSM is set to IDLE.
- rx-side activity has no effect on this block; full duplex is independent.

Test Plan:
- Reset idle: hold rst_n=0, then release → tx=1, tx_ready=1, fifo_count=0, is_transmitting=0 for 100 cycles with no push.
- Single byte (CLKS_PER_BIT=4): push 0xA5 at edge N:
  - tx=0 for cycles N+1..N+4, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then stop=1 for 4 cycles.
  - is_transmitting falls at N+41. A line decoder recovers 0xA5.
- Back-to-back: push 0x00, 0xFF, 0x55 on consecutive edges → three contiguous 40-cycle frames with no idle cycle between stop and next start; fifo_count peaks at 2.
- Full FIFO (depth 8): push 10 bytes with tx_valid held high:
  - 9 accepted immediately (1 in flight + 8 queued), then tx_ready=0 and fifo_count=8.
  - The 10th byte is accepted on the cycle after the next pop.
  - All bytes are sent in push order.
- Simultaneous push/pop: with 1 byte queued, push at the same edge the FSM pops → fifo_count unchanged; both bytes are transmitted in order.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 with 2 bytes queued → tx=1 asynchronously, fifo_count=0. After release, no further frame is sent.
